// File: rtl/stepper_pkg.sv
// Shared types and helpers for the step/dir decoder.
//   DIR_NEG      - dir level that means "count down"
//   move_state_e - move-tracking FSM states
//   sat_step     - +/-1 step on a signed value clamped to a given bit width
package stepper_pkg;

  localparam logic DIR_NEG = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StDrain,
    StReport
  } move_state_e;

  // Steps val by one in the direction given by neg and clamps it to the signed
  // range of a width-bit register. Callers truncate the result to that width.
  // clamped is set when the step would have left the range.
  function automatic int sat_step(input int val, input logic neg, input int unsigned width,
                                  output logic clamped);
    int hi;
    int lo;
    int res;
    hi      = (1 << (width - 1)) - 1;
    lo      = -hi - 1;
    clamped = 1'b0;
    if (neg == DIR_NEG) begin
      if (val <= lo) begin
        clamped = 1'b1;
        res     = lo;
      end else begin
        res = val - 1;
      end
    end else begin
      if (val >= hi) begin
        clamped = 1'b1;
        res     = hi;
      end else begin
        res = val + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/step_dir_axis.sv
// One decoder axis: synchronizes step/dir, detects rising step edges and keeps
// the absolute position, the per-move step count and the sticky flags.
//   clk, reset_n - clock, asynchronous active-low reset
//   step, dir    - asynchronous step pulse and direction (dir=1 counts down)
//   zero         - clear position and sticky flags; drops a coincident step
//   move_clr     - clear the move counter
//   move_en      - count steps into the move counter
//   pos          - signed absolute position
//   move_cnt     - signed steps counted since the last move_clr
//   sat          - sticky: position or move counter clamped
//   dir_err      - sticky: dir changed on the sampled step edge
module step_dir_axis
  import stepper_pkg::*;
#(
  parameter int unsigned POS_BITS    = 16,
  parameter int unsigned MOVE_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        step,
  input  logic                        dir,
  input  logic                        zero,
  input  logic                        move_clr,
  input  logic                        move_en,
  output logic signed [POS_BITS-1:0]  pos,
  output logic signed [MOVE_BITS-1:0] move_cnt,
  output logic                        sat,
  output logic                        dir_err
);

  logic [SYNC_STAGES-1:0] step_sync_q;
  logic [SYNC_STAGES-1:0] dir_sync_q;
  logic                   step_prev_q;
  logic                   dir_prev_q;

  logic signed [POS_BITS-1:0]  pos_q, pos_d;
  logic signed [MOVE_BITS-1:0] move_q, move_d;
  logic                        sat_q, sat_d;
  logic                        dir_err_q, dir_err_d;

  logic step_s;
  logic dir_s;
  logic step_take;
  int   pos_sum;
  int   move_sum;
  logic pos_clamp;
  logic move_clamp;

  assign step_s = step_sync_q[SYNC_STAGES-1];
  assign dir_s  = dir_sync_q[SYNC_STAGES-1];
  // zero has priority: a step edge in the same cycle is discarded entirely.
  assign step_take = step_s & ~step_prev_q & ~zero;

  always_comb begin
    pos_d     = pos_q;
    move_d    = move_q;
    sat_d     = sat_q;
    dir_err_d = dir_err_q;
    pos_sum   = sat_step(int'(pos_q), dir_s, POS_BITS, pos_clamp);
    move_sum  = sat_step(int'(move_q), dir_s, MOVE_BITS, move_clamp);

    if (step_take) begin
      pos_d = POS_BITS'(pos_sum);
      sat_d = sat_d | pos_clamp;
      // Step is still counted, using the newly sampled direction.
      if (dir_s != dir_prev_q) begin
        dir_err_d = 1'b1;
      end
      if (move_en) begin
        move_d = MOVE_BITS'(move_sum);
        sat_d  = sat_d | move_clamp;
      end
    end

    if (move_clr) begin
      move_d = '0;
    end

    if (zero) begin
      pos_d     = '0;
      sat_d     = 1'b0;
      dir_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_sync_q <= '0;
      dir_sync_q  <= '0;
      step_prev_q <= 1'b0;
      dir_prev_q  <= 1'b0;
      pos_q       <= '0;
      move_q      <= '0;
      sat_q       <= 1'b0;
      dir_err_q   <= 1'b0;
    end else begin
      step_sync_q <= {step_sync_q[SYNC_STAGES-2:0], step};
      dir_sync_q  <= {dir_sync_q[SYNC_STAGES-2:0], dir};
      step_prev_q <= step_s;
      dir_prev_q  <= dir_s;
      pos_q       <= pos_d;
      move_q      <= move_d;
      sat_q       <= sat_d;
      dir_err_q   <= dir_err_d;
    end
  end

  assign pos      = pos_q;
  assign move_cnt = move_q;
  assign sat      = sat_q;
  assign dir_err  = dir_err_q;

endmodule

// File: rtl/step_dir_decoder_xy.sv
// Two-axis step/dir decoder: tracks absolute X/Y positions and reports the
// signed step count of each completed move.
//   clk, reset_n               - clock, asynchronous active-low reset
//   step_x/dir_x, step_y/dir_y - asynchronous step pulses and directions
//   zero                       - clear positions and sticky flags
//   move_start                 - 1-cycle pulse, begins (or restarts) a move
//   move_done                  - generator's sequence-finished level
//   pos_x, pos_y               - signed absolute positions
//   last_move_x, last_move_y   - signed steps of the last completed move
//   move_valid                 - 1-cycle pulse when last_move_* update
//   busy                       - move FSM not idle
//   sat_x, sat_y               - sticky saturation flags
//   dir_err                    - sticky dir-change-on-step-edge flag
`ifndef BYTE_BITS
`define BYTE_BITS 8
`endif

module step_dir_decoder_xy
  import stepper_pkg::*;
#(
  parameter int unsigned POS_BITS    = 16,
  parameter int unsigned MOVE_BITS   = `BYTE_BITS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        step_x,
  input  logic                        dir_x,
  input  logic                        step_y,
  input  logic                        dir_y,
  input  logic                        zero,
  input  logic                        move_start,
  input  logic                        move_done,
  output logic signed [POS_BITS-1:0]  pos_x,
  output logic signed [POS_BITS-1:0]  pos_y,
  output logic signed [MOVE_BITS-1:0] last_move_x,
  output logic signed [MOVE_BITS-1:0] last_move_y,
  output logic                        move_valid,
  output logic                        busy,
  output logic                        sat_x,
  output logic                        sat_y,
  output logic                        dir_err
);

  localparam int unsigned DrainBits = $clog2(SYNC_STAGES + 2);
  // Covers steps already inside the synchronizers when move_done rises.
  localparam logic [DrainBits-1:0] DrainLoad = DrainBits'(SYNC_STAGES + 1);

  move_state_e                 state_q;
  logic [DrainBits-1:0]        drain_q;
  logic                        move_done_q;
  logic signed [MOVE_BITS-1:0] last_x_q;
  logic signed [MOVE_BITS-1:0] last_y_q;
  logic                        move_valid_q;
  logic                        busy_q;

  logic                        move_en;
  logic                        done_rise;
  logic signed [MOVE_BITS-1:0] move_cnt_x;
  logic signed [MOVE_BITS-1:0] move_cnt_y;
  logic                        dir_err_x;
  logic                        dir_err_y;

  assign move_en   = (state_q == StCount) || (state_q == StDrain);
  assign done_rise = move_done & ~move_done_q;

  // move_start clears the counters in every state; in REPORT the copy into
  // last_move_* uses the pre-clear values on the same edge.
  step_dir_axis #(
    .POS_BITS   (POS_BITS),
    .MOVE_BITS  (MOVE_BITS),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_axis_x (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (step_x),
    .dir     (dir_x),
    .zero    (zero),
    .move_clr(move_start),
    .move_en (move_en),
    .pos     (pos_x),
    .move_cnt(move_cnt_x),
    .sat     (sat_x),
    .dir_err (dir_err_x)
  );

  step_dir_axis #(
    .POS_BITS   (POS_BITS),
    .MOVE_BITS  (MOVE_BITS),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_axis_y (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (step_y),
    .dir     (dir_y),
    .zero    (zero),
    .move_clr(move_start),
    .move_en (move_en),
    .pos     (pos_y),
    .move_cnt(move_cnt_y),
    .sat     (sat_y),
    .dir_err (dir_err_y)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      drain_q      <= '0;
      move_done_q  <= 1'b0;
      last_x_q     <= '0;
      last_y_q     <= '0;
      move_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      move_done_q  <= move_done;
      move_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (move_start) begin
            state_q <= StCount;
            busy_q  <= 1'b1;
          end
        end
        StCount: begin
          if (move_start) begin
            state_q <= StCount;
          end else if (done_rise) begin
            state_q <= StDrain;
            drain_q <= DrainLoad;
          end
        end
        StDrain: begin
          if (move_start) begin
            state_q <= StCount;
          end else if (drain_q == '0) begin
            state_q <= StReport;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        StReport: begin
          last_x_q     <= move_cnt_x;
          last_y_q     <= move_cnt_y;
          move_valid_q <= 1'b1;
          if (move_start) begin
            state_q <= StCount;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign last_move_x = last_x_q;
  assign last_move_y = last_y_q;
  assign move_valid  = move_valid_q;
  assign busy        = busy_q;
  assign dir_err     = dir_err_x | dir_err_y;

endmodule

// File: tb/tb_step_dir_decoder_xy.sv
// Randomized scoreboard bench for step_dir_decoder_xy. A narrow position width
// keeps the saturation corners reachable in a short run.
module tb_step_dir_decoder_xy;

  localparam int unsigned POS_BITS    = 10;
  localparam int unsigned MOVE_BITS   = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int PMAX = (1 << (POS_BITS - 1)) - 1;
  localparam int PMIN = -(1 << (POS_BITS - 1));
  localparam int MMAX = (1 << (MOVE_BITS - 1)) - 1;
  localparam int MMIN = -(1 << (MOVE_BITS - 1));

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic step_x = 1'b0, dir_x = 1'b0, step_y = 1'b0, dir_y = 1'b0;
  logic zero = 1'b0, move_start = 1'b0, move_done = 1'b0;
  logic signed [POS_BITS-1:0]  pos_x, pos_y;
  logic signed [MOVE_BITS-1:0] last_move_x, last_move_y;
  logic move_valid, busy, sat_x, sat_y, dir_err;

  step_dir_decoder_xy #(
    .POS_BITS   (POS_BITS),
    .MOVE_BITS  (MOVE_BITS),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .step_x     (step_x),
    .dir_x      (dir_x),
    .step_y     (step_y),
    .dir_y      (dir_y),
    .zero       (zero),
    .move_start (move_start),
    .move_done  (move_done),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .last_move_x(last_move_x),
    .last_move_y(last_move_y),
    .move_valid (move_valid),
    .busy       (busy),
    .sat_x      (sat_x),
    .sat_y      (sat_y),
    .dir_err    (dir_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int x;
    int y;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Reference model: intended positions/move counts, clamped to register ranges.
  int mpos[2];
  int mmove[2];
  bit msat[2];
  bit merr;
  bit in_move;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mpos    = '{0, 0};
    mmove   = '{0, 0};
    msat    = '{0, 0};
    merr    = 0;
    in_move = 0;
  endtask

  task automatic model_step(input int ax, input bit neg);
    int d;
    d = neg ? -1 : 1;
    if (mpos[ax] + d > PMAX || mpos[ax] + d < PMIN) msat[ax] = 1;
    else mpos[ax] += d;
    if (in_move) begin
      if (mmove[ax] + d > MMAX || mmove[ax] + d < MMIN) msat[ax] = 1;
      else mmove[ax] += d;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".pos_x"}, int'(pos_x), mpos[0]);
    check({tag, ".pos_y"}, int'(pos_y), mpos[1]);
    check({tag, ".sat_x"}, int'(sat_x), int'(msat[0]));
    check({tag, ".sat_y"}, int'(sat_y), int'(msat[1]));
    check({tag, ".dir_err"}, int'(dir_err), int'(merr));
  endtask

  // One clean step on the selected axes: dir settles first, 2-cycle high/low.
  task automatic pulse_steps(input bit sx, input bit sy, input bit dx, input bit dy);
    dir_x = dx;
    dir_y = dy;
    tick();
    tick();
    step_x = sx;
    step_y = sy;
    if (sx) model_step(0, dx);
    if (sy) model_step(1, dy);
    tick();
    tick();
    step_x = 1'b0;
    step_y = 1'b0;
    tick();
    tick();
  endtask

  task automatic start_move();
    move_start = 1'b1;
    tick();
    move_start = 1'b0;
    in_move = 1;
    mmove   = '{0, 0};
    check("busy_after_start", int'(busy), 1);
  endtask

  // Optionally lands a final X step one cycle before move_done rises.
  task automatic finish_move(input bit late, input bit dx);
    int  n;
    bit  seen;
    exp_t e;
    if (late) begin
      dir_x = dx;
      tick();
      tick();
      step_x = 1'b1;
      model_step(0, dx);
      tick();
    end
    e.x = mmove[0];
    e.y = mmove[1];
    sb.push_back(e);
    in_move   = 0;
    move_done = 1'b1;
    n    = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      seen = move_valid;
    end
    if (!seen) n = 99;
    check("move_valid_latency", n, SYNC_STAGES + 4);
    #1;
    step_x    = 1'b0;
    move_done = 1'b0;
    tick();
    tick();
    tick();
    check("busy_after_report", int'(busy), 0);
  endtask

  task automatic run_move(input int nx, input int ny, input bit late);
    int ax, ay;
    bit lt;
    start_move();
    ax = (nx < 0) ? -nx : nx;
    ay = (ny < 0) ? -ny : ny;
    lt = late && (ax > 0);
    if (lt) ax--;
    while (ax > 0 || ay > 0) begin
      pulse_steps(ax > 0, ay > 0, nx < 0, ny < 0);
      if (ax > 0) ax--;
      if (ay > 0) ay--;
    end
    finish_move(lt, nx < 0);
  endtask

  task automatic do_zero();
    zero = 1'b1;
    tick();
    zero = 1'b0;
    mpos = '{0, 0};
    msat = '{0, 0};
    merr = 0;
    tick();
  endtask

  // Monitor: every move_valid must match the oldest expected report.
  always @(negedge clk) begin
    if (reset_n && move_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_move_valid: got last_move=(%0d,%0d) expected no report",
                 last_move_x, last_move_y);
      end else begin
        mon_e = sb.pop_front();
        check("last_move_x", int'(last_move_x), mon_e.x);
        check("last_move_y", int'(last_move_y), mon_e.y);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    tick();
    tick();
    check("rst.last_move_x", int'(last_move_x), 0);
    check("rst.last_move_y", int'(last_move_y), 0);
    check("rst.move_valid", int'(move_valid), 0);
    check("rst.busy", int'(busy), 0);
    check_state("rst");
    reset_n = 1'b1;
    tick();

    // 5 forward then 3 reverse X steps in one move.
    start_move();
    for (int i = 0; i < 5; i++) pulse_steps(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) pulse_steps(1, 0, 1, 0);
    finish_move(0, 0);
    check_state("move_5_3");

    // Loopback-style moves, final step close to move_done.
    run_move(-7, 12, 1);
    check_state("loop1");
    run_move(-7, 12, 1);
    check_state("loop2");

    // Random moves with random idle steps in between.
    for (int r = 0; r < 6; r++) begin
      int nx, ny;
      nx = int'($urandom_range(40)) - 20;
      ny = int'($urandom_range(40)) - 20;
      run_move(nx, ny, 1'($urandom_range(1)));
      for (int k = 0; k < 3; k++) begin
        pulse_steps(1'($urandom_range(1)), 1'($urandom_range(1)),
                    1'($urandom_range(1)), 1'($urandom_range(1)));
      end
      check_state("rand");
    end

    // Restart mid-COUNT: only the second part is reported.
    start_move();
    for (int i = 0; i < 4; i++) pulse_steps(1, 0, 0, 0);
    start_move();
    for (int i = 0; i < 2; i++) pulse_steps(1, 0, 0, 0);
    finish_move(0, 0);
    check_state("restart");

    // Move counter saturation, then zero.
    run_move(130, 0, 0);
    check_state("move_sat");
    do_zero();
    check_state("zero1");

    // Position saturation at the positive limit, then zero.
    for (int i = 0; i < PMAX + 3; i++) pulse_steps(1, 0, 0, 0);
    check_state("pos_sat");
    do_zero();
    check_state("zero2");

    // dir changes on the same cycle as the step edge.
    dir_x = 1'b0;
    tick();
    tick();
    tick();
    dir_x  = 1'b1;
    step_x = 1'b1;
    model_step(0, 1);
    merr = 1;
    tick();
    tick();
    step_x = 1'b0;
    tick();
    tick();
    tick();
    check_state("dir_err");
    do_zero();
    check_state("zero3");

    // Reset while draining: everything clears, no report afterwards.
    start_move();
    pulse_steps(1, 1, 0, 1);
    pulse_steps(1, 1, 0, 1);
    move_done = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_drain.busy", int'(busy), 0);
    check("rst_drain.move_valid", int'(move_valid), 0);
    check("rst_drain.last_move_x", int'(last_move_x), 0);
    check_state("rst_drain");
    move_done = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("rst_drain.busy_after", int'(busy), 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
